// File: rtl/multi_digit_counter.sv
// multi_digit_counter
// Parametrised cascade of DIGITS digits, each counting modulo MODULUS in DW bits.
// Supports enable, synchronous clear, parallel load (invalid digits are
// replaced by zero and flagged), and a combinational terminal-count output.
// Optional feature macro: COUNTER_UPDOWN_EN
//   defined   -> up_dn selects up (1) or down (0) counting
//   undefined -> up_dn is ignored and the counter only counts up
module multi_digit_counter #(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 10,
    parameter int DW      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    input  logic                 up_dn,
    output logic [DIGITS*DW-1:0] count,
    output logic                 tc,
    output logic                 load_err
);

    // Largest legal digit value and the first illegal one (DW+1 bits so that
    // MODULUS == 2**DW is representable and simply never flags an error).
    localparam logic [DW-1:0] DIGIT_MAX   = DW'(MODULUS - 1);
    localparam logic [DW:0]   DIGIT_LIMIT = (DW + 1)'(MODULUS);

    // carry_chain[i] : every digit below i sits at DIGIT_MAX, so digit i steps up.
    // carry_chain[DIGITS] therefore means the whole counter is at the up terminal.
    logic [DIGITS:0]   carry_chain;
    logic [DIGITS-1:0] load_bad;
    logic              count_up;
    logic              at_terminal;
    logic              load_err_q;
    logic              load_err_d;

    assign carry_chain[0] = 1'b1;

`ifdef COUNTER_UPDOWN_EN
    // borrow_chain[i] : every digit below i is zero, so digit i steps down.
    logic [DIGITS:0] borrow_chain;

    assign borrow_chain[0] = 1'b1;
    assign count_up        = up_dn;
    assign at_terminal     = count_up ? carry_chain[DIGITS] : borrow_chain[DIGITS];
`else
    // Direction input exists for pin compatibility only.
    logic unused_up_dn;

    assign unused_up_dn = up_dn;
    assign count_up     = 1'b1;
    assign at_terminal  = carry_chain[DIGITS];
`endif

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [DW-1:0] digit_q;
            logic [DW-1:0] digit_d;
            logic [DW-1:0] digit_inc;
            logic [DW-1:0] digit_step;
            logic [DW-1:0] load_field;
            logic [DW-1:0] load_digit;
            logic          digit_is_max;

            assign digit_is_max        = (digit_q == DIGIT_MAX);
            assign carry_chain[gi + 1] = carry_chain[gi] & digit_is_max;
            assign digit_inc           = digit_is_max ? '0 : digit_q + 1'b1;

`ifdef COUNTER_UPDOWN_EN
            logic          digit_is_zero;
            logic [DW-1:0] digit_dec;

            assign digit_is_zero        = (digit_q == '0);
            assign borrow_chain[gi + 1] = borrow_chain[gi] & digit_is_zero;
            assign digit_dec            = digit_is_zero ? DIGIT_MAX : digit_q - 1'b1;
            assign digit_step = count_up ? (carry_chain[gi]  ? digit_inc : digit_q)
                                         : (borrow_chain[gi] ? digit_dec : digit_q);
`else
            assign digit_step = carry_chain[gi] ? digit_inc : digit_q;
`endif

            // Out-of-range load fields are forced to zero; the flag feeds load_err.
            assign load_field   = load_val[gi*DW +: DW];
            assign load_bad[gi] = ({1'b0, load_field} >= DIGIT_LIMIT);
            assign load_digit   = load_bad[gi] ? '0 : load_field;

            // Next digit value: clear beats load beats enabled step beats hold.
            always_comb begin
                digit_d = digit_q;
                if (clr) begin
                    digit_d = '0;
                end else if (load) begin
                    digit_d = load_digit;
                end else if (en) begin
                    digit_d = digit_step;
                end
            end

            // Digit register, cleared asynchronously by reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    digit_q <= '0;
                end else begin
                    digit_q <= digit_d;
                end
            end

            assign count[gi*DW +: DW] = digit_q;
        end
    endgenerate

    // load_err is raised only by a load that actually takes effect (not overridden by clr).
    always_comb begin
        load_err_d = 1'b0;
        if (!clr && load) begin
            load_err_d = |load_bad;
        end
    end

    // One-cycle error pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign load_err = load_err_q;

    // Terminal count is combinational; rst_n gates it so it stays low in reset.
    assign tc = rst_n & en & ~clr & ~load & at_terminal;

endmodule

// File: tb/tb_multi_digit_counter.sv
// Self-checking bench for multi_digit_counter (DIGITS=2, MODULUS=10, DW=4).
// The reference model keeps the whole count as one integer modulo MODULUS**DIGITS
// and converts it to packed digits only for comparison.
module tb_multi_digit_counter;

    localparam int DIGITS  = 2;
    localparam int MODULUS = 10;
    localparam int DW      = 4;
    localparam int W       = DIGITS * DW;
    localparam int N       = MODULUS ** DIGITS;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic         up_dn;
    logic [W-1:0] count;
    logic         tc;
    logic         load_err;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int v     = 0;
    bit err_m = 1'b0;

    multi_digit_counter #(
        .DIGITS (DIGITS),
        .MODULUS(MODULUS),
        .DW     (DW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .load    (load),
        .load_val(load_val),
        .up_dn   (up_dn),
        .count   (count),
        .tc      (tc),
        .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] pack(input int val);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = val;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*DW +: DW] = DW'(x % MODULUS);
            x = x / MODULUS;
        end
        return r;
    endfunction

    // Integer value produced by a load, plus whether any field was illegal.
    function automatic int load_value(input logic [W-1:0] lv, output bit bad);
        int val;
        int d;
        val = 0;
        bad = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(lv[i*DW +: DW]);
            if (d >= MODULUS) begin
                bad = 1'b1;
                d   = 0;
            end
            val = val * MODULUS + d;
        end
        return val;
    endfunction

    function automatic bit eff_up(input bit u);
`ifdef COUNTER_UPDOWN_EN
        return u;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs shortly after an edge, check tc before the
    // next edge, then check count/load_err just after it.
    task automatic step(input bit e, input bit c, input bit l, input logic [W-1:0] lv, input bit u);
        bit exp_tc;
        bit up;
        bit bad;
        en       = e;
        clr      = c;
        load     = l;
        load_val = lv;
        up_dn    = u;
        #3;
        up     = eff_up(u);
        exp_tc = e && !c && !l && (v == (up ? N - 1 : 0));
        check("tc", 32'(tc), 32'(exp_tc));
        @(posedge clk);
        if (c) begin
            v     = 0;
            err_m = 1'b0;
        end else if (l) begin
            v     = load_value(lv, bad);
            err_m = bad;
        end else begin
            if (e) v = up ? (v + 1) % N : (v + N - 1) % N;
            err_m = 1'b0;
        end
        #1;
        check("count", 32'(count), 32'(pack(v)));
        check("load_err", 32'(load_err), 32'(err_m));
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        up_dn    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 32'(count), 32'(pack(0)));
        check("reset_load_err", 32'(load_err), 32'h0);
        check("reset_tc", 32'(tc), 32'h0);
        en    = 1'b0;
        rst_n = 1'b1;
        v     = 0;
        err_m = 1'b0;

        // Reset mid-count at 37, held three cycles, then count 01, 02.
        step(1'b0, 1'b0, 1'b1, 8'h37, 1'b1);
        en    = 1'b1;
        up_dn = 1'b1;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'(pack(0)));
        check("async_rst_tc", 32'(tc), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("held_rst_count", 32'(count), 32'(pack(0)));
        rst_n = 1'b1;
        v     = 0;
        err_m = 1'b0;
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Reset clears a pending load_err pulse immediately.
        step(1'b0, 1'b0, 1'b1, 8'h9C, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_clears_load_err", 32'(load_err), 32'h0);
        check("rst_clears_count", 32'(count), 32'(pack(0)));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v     = 0;
        err_m = 1'b0;

        // Full up sweep from 00 through the 99 -> 00 wrap.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < N + 2; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Load valid value with en high, then one with an illegal low digit.
        step(1'b1, 1'b0, 1'b1, 8'h47, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Priority: clr + load + en at 63, then hold four cycles.
        step(1'b0, 1'b0, 1'b1, 8'h63, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'h5A, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // 98 -> 99 -> 00 with up_dn low (up only when the direction feature is off).
        step(1'b0, 1'b0, 1'b1, 8'h98, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

`ifdef COUNTER_UPDOWN_EN
        // Down: 10 -> 09, and 00 wraps to 99 with tc high.
        step(1'b0, 1'b0, 1'b1, 8'h10, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
`endif

        // Randomised traffic against the integer model.
        for (int i = 0; i < 400; i++) begin
            bit e;
            bit c;
            bit l;
            bit u;
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 31) == 0);
            l = ($urandom_range(0, 15) == 0);
            u = ($urandom_range(0, 3) != 0);
            step(e, c, l, W'($urandom), u);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
